// File: rtl/gpfc_pkg.sv
// Shared gPFC types and constants for the pause tracker and bypass checker.
package gpfc_pkg;

  localparam int GPFC_RANK_W   = 18;
  localparam int GPFC_QUANTA_W = 16;

  typedef logic [GPFC_RANK_W-1:0]   rank_t;
  typedef logic [GPFC_QUANTA_W-1:0] quanta_t;

  typedef enum logic {
    IDLE   = 1'b0,
    PAUSED = 1'b1
  } state_e;

endpackage

// File: rtl/gpfc_quantum_timer.sv
// Prescaled quanta countdown: load, clear and a one-cycle expire pulse.
module gpfc_quantum_timer
  import gpfc_pkg::*;
#(
  parameter int QUANTA_WIDTH   = GPFC_QUANTA_W,
  parameter int QUANTUM_CYCLES = 512,
  parameter int PRESCALE_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic [QUANTA_WIDTH-1:0] quanta_i,
  input  logic                    clear_i,
  output logic [QUANTA_WIDTH-1:0] remaining_o,
  output logic                    expire_o
);

  if (QUANTUM_CYCLES < 2 ||
      (1 << PRESCALE_WIDTH) < QUANTUM_CYCLES) begin : g_bad_cfg
    $error("gpfc_quantum_timer: bad prescaler config");
  end

  localparam logic [PRESCALE_WIDTH-1:0] PRE_LAST =
    PRESCALE_WIDTH'(QUANTUM_CYCLES - 1);

  logic [PRESCALE_WIDTH-1:0] pre_q, pre_d;
  logic [QUANTA_WIDTH-1:0]   rem_q, rem_d;
  logic                      running;
  logic                      wrap;

  assign running = (rem_q != '0);
  assign wrap    = (pre_q == PRE_LAST);

  // Fires on the edge that takes remaining from 1 to 0.
  assign expire_o = running & wrap &
                    (rem_q == QUANTA_WIDTH'(1));

  always_comb begin
    pre_d = pre_q;
    rem_d = rem_q;
    if (clear_i) begin
      pre_d = '0;
      rem_d = '0;
    end else if (load_i) begin
      pre_d = '0;
      rem_d = quanta_i;
    end else if (running) begin
      if (wrap) begin
        pre_d = '0;
        rem_d = rem_q - QUANTA_WIDTH'(1);
      end else begin
        pre_d = pre_q + PRESCALE_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      rem_q <= '0;
    end else begin
      pre_q <= pre_d;
      rem_q <= rem_d;
    end
  end

  assign remaining_o = rem_q;

endmodule

// File: rtl/gpfc_pause_tracker.sv
// gPFC pause tracker: holds and ages the active pause rank.
// Optional GPFC_PAUSE_MERGE_EN merges overlapping pauses.
module gpfc_pause_tracker
  import gpfc_pkg::*;
#(
  parameter int PIFO_RANK_WIDTH = GPFC_RANK_W,
  parameter int QUANTA_WIDTH    = GPFC_QUANTA_W,
  parameter int QUANTUM_CYCLES  = 512,
  parameter int PRESCALE_WIDTH  = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_axis_pause_valid,
  input  logic [PIFO_RANK_WIDTH-1:0] s_axis_pause_rank,
  input  logic [QUANTA_WIDTH-1:0]    s_axis_pause_quanta,
  output logic                       m_axis_gpfc_valid,
  output logic [PIFO_RANK_WIDTH-1:0] m_axis_gpfc_pause_rank,
  output logic [QUANTA_WIDTH-1:0]    m_axis_pause_remaining,
  output logic [15:0]                m_axis_pause_event_cnt
);

  state_e                     state_q;
  logic                       valid_q;
  logic [PIFO_RANK_WIDTH-1:0] rank_q;
  logic [15:0]                cnt_q;

  logic                       ev_pause;
  logic                       ev_resume;
  logic                       paused;
  logic                       load;
  logic                       expire;
  logic [QUANTA_WIDTH-1:0]    remaining;
  logic [PIFO_RANK_WIDTH-1:0] rank_new;

  assign ev_pause  = s_axis_pause_valid &
                     (s_axis_pause_quanta != '0);
  assign ev_resume = s_axis_pause_valid &
                     (s_axis_pause_quanta == '0);
  assign paused    = (state_q == PAUSED);

`ifdef GPFC_PAUSE_MERGE_EN
  // Only a longer pause restarts the countdown; ranks keep the tighter bound.
  assign load = ev_pause &
                (!paused || s_axis_pause_quanta > remaining);
  assign rank_new = (paused && rank_q < s_axis_pause_rank) ?
                    rank_q : s_axis_pause_rank;
`else
  assign load     = ev_pause;
  assign rank_new = s_axis_pause_rank;
`endif

  gpfc_quantum_timer #(
    .QUANTA_WIDTH   (QUANTA_WIDTH),
    .QUANTUM_CYCLES (QUANTUM_CYCLES),
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load),
    .quanta_i    (s_axis_pause_quanta),
    .clear_i     (ev_resume),
    .remaining_o (remaining),
    .expire_o    (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      rank_q  <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ev_pause) begin
            state_q <= PAUSED;
            valid_q <= 1'b1;
            rank_q  <= rank_new;
            cnt_q   <= cnt_q + 16'd1;
          end
        end
        PAUSED: begin
          if (ev_pause) begin
            rank_q <= rank_new;
            cnt_q  <= cnt_q + 16'd1;
            if (!load && expire) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
            end
          end else if (ev_resume || expire) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign m_axis_gpfc_valid      = valid_q;
  assign m_axis_gpfc_pause_rank = rank_q;
  assign m_axis_pause_remaining = remaining;
  assign m_axis_pause_event_cnt = cnt_q;

endmodule

// File: tb/tb_gpfc_pause_tracker.sv
// Bench for gpfc_pause_tracker: vector table, merge corner, random vs model.
module tb_gpfc_pause_tracker;

  localparam int RW = 18;
  localparam int QW = 16;
  localparam int QC = 4;
  localparam int PW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          ev_v;
  logic [RW-1:0] ev_r;
  logic [QW-1:0] ev_q;
  logic          o_valid;
  logic [RW-1:0] o_rank;
  logic [QW-1:0] o_rem;
  logic [15:0]   o_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpfc_pause_tracker #(
    .PIFO_RANK_WIDTH (RW),
    .QUANTA_WIDTH    (QW),
    .QUANTUM_CYCLES  (QC),
    .PRESCALE_WIDTH  (PW)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .s_axis_pause_valid     (ev_v),
    .s_axis_pause_rank      (ev_r),
    .s_axis_pause_quanta    (ev_q),
    .m_axis_gpfc_valid      (o_valid),
    .m_axis_gpfc_pause_rank (o_rank),
    .m_axis_pause_remaining (o_rem),
    .m_axis_pause_event_cnt (o_cnt)
  );

  task automatic cmp(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: a pause is an absolute end time on the edge counter.
  longint        now_c = 0;
  longint        end_c = 0;
  logic [RW-1:0] m_rank = '0;
  logic [15:0]   m_cnt = '0;

  function automatic longint m_rem();
    if (now_c < end_c) return (end_c - now_c + QC - 1) / QC;
    return 0;
  endfunction

  task automatic mdl_edge();
    bit     was_on;
    longint rem_b;
    was_on = (now_c < end_c);
    rem_b  = m_rem();
    now_c++;
    if (rst) begin
      end_c  = now_c;
      m_rank = '0;
      m_cnt  = '0;
    end else if (ev_v && ev_q == 0) begin
      if (was_on) end_c = now_c;
    end else if (ev_v) begin
      m_cnt++;
`ifdef GPFC_PAUSE_MERGE_EN
      if (!was_on || ev_q > rem_b)
        end_c = now_c + longint'(ev_q) * QC;
      if (!was_on || ev_r < m_rank) m_rank = ev_r;
`else
      end_c  = now_c + longint'(ev_q) * QC;
      m_rank = ev_r;
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    mdl_edge();
    @(negedge clk);
  endtask

  task automatic idle_in();
    rst  = 1'b0;
    ev_v = 1'b0;
    ev_r = '0;
    ev_q = '0;
  endtask

  typedef struct {
    logic          rst;
    logic          v;
    logic [RW-1:0] rank;
    logic [QW-1:0] q;
    int            idle;
    logic          ev;
    logic [RW-1:0] er;
    logic [QW-1:0] erem;
    logic [15:0]   ecnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic v, int rk, int q,
                              int idle, logic ev, int er,
                              int erem, int ecnt);
    vec_t t;
    t.rst = r; t.v = v;
    t.rank = RW'(rk); t.q = QW'(q);
    t.idle = idle; t.ev = ev;
    t.er = RW'(er); t.erem = QW'(erem);
    t.ecnt = 16'(ecnt);
    return t;
  endfunction

  initial begin
    idle_in();
    rst = 1'b1;
    // rst, v, rank, q, idle | valid, rank, rem, cnt
    tbl.push_back(mk(1, 0,   0,  0, 0, 0,   0,  0, 0));
    tbl.push_back(mk(1, 1,   5,  3, 0, 0,   0,  0, 0));
    tbl.push_back(mk(1, 0,   0,  0, 0, 0,   0,  0, 0));
    tbl.push_back(mk(0, 0,   0,  0, 0, 0,   0,  0, 0));
    tbl.push_back(mk(0, 1,   9,  0, 0, 0,   0,  0, 0));
    tbl.push_back(mk(0, 1, 100,  3, 0, 1, 100,  3, 1));
    tbl.push_back(mk(0, 0,   0,  0, 2, 1, 100,  3, 1));
    tbl.push_back(mk(0, 0,   0,  0, 0, 1, 100,  2, 1));
    tbl.push_back(mk(0, 0,   0,  0, 6, 1, 100,  1, 1));
    tbl.push_back(mk(0, 0,   0,  0, 0, 0, 100,  0, 1));
    tbl.push_back(mk(0, 1,  50, 10, 0, 1,  50, 10, 2));
    tbl.push_back(mk(0, 0,   0,  0, 2, 1,  50, 10, 2));
    tbl.push_back(mk(0, 1,  77,  0, 0, 0,  50,  0, 2));
    tbl.push_back(mk(0, 1,   7,  1, 0, 1,   7,  1, 3));
    tbl.push_back(mk(0, 0,   0,  0, 2, 1,   7,  1, 3));
    tbl.push_back(mk(0, 1,   9,  2, 0, 1,   9,  2, 4));
    tbl.push_back(mk(0, 0,   0,  0, 6, 1,   9,  1, 4));
    tbl.push_back(mk(0, 0,   0,  0, 0, 0,   9,  0, 4));
    tbl.push_back(mk(0, 1,   0,  2, 0, 1,   0,  2, 5));
    tbl.push_back(mk(1, 0,   0,  0, 0, 0,   0,  0, 0));

    @(negedge clk);
    foreach (tbl[i]) begin
      rst  = tbl[i].rst;
      ev_v = tbl[i].v;
      ev_r = tbl[i].rank;
      ev_q = tbl[i].q;
      tick();
      idle_in();
      repeat (tbl[i].idle) tick();
      cmp($sformatf("vec%0d valid", i), 32'(o_valid),
          32'(tbl[i].ev));
      cmp($sformatf("vec%0d rank", i), 32'(o_rank),
          32'(tbl[i].er));
      cmp($sformatf("vec%0d rem", i), 32'(o_rem),
          32'(tbl[i].erem));
      cmp($sformatf("vec%0d cnt", i), 32'(o_cnt),
          32'(tbl[i].ecnt));
    end

    // Overlapping pause: rank 40/q5 then rank 60/q2 two cycles later.
    rst = 1'b1;
    tick();
    idle_in();
    ev_v = 1'b1; ev_r = 40; ev_q = 5;
    tick();
    idle_in();
    repeat (2) tick();
    ev_v = 1'b1; ev_r = 60; ev_q = 2;
    tick();
    idle_in();
    cmp("merge valid", 32'(o_valid), 32'd1);
    cmp("merge cnt", 32'(o_cnt), 32'd2);
`ifdef GPFC_PAUSE_MERGE_EN
    cmp("merge rank", 32'(o_rank), 32'd40);
    cmp("merge rem", 32'(o_rem), 32'd5);
`else
    cmp("merge rank", 32'(o_rank), 32'd60);
    cmp("merge rem", 32'(o_rem), 32'd2);
`endif

    // Reset in the middle of an active pause.
    rst = 1'b1;
    tick();
    idle_in();
    cmp("midrst valid", 32'(o_valid), 32'd0);
    cmp("midrst rem", 32'(o_rem), 32'd0);
    cmp("midrst cnt", 32'(o_cnt), 32'd0);

    // Random traffic against the end-time model.
    for (int n = 0; n < 4000; n++) begin
      rst  = ($urandom_range(299) == 0);
      ev_v = ($urandom_range(5) == 0);
      ev_r = RW'($urandom_range(63));
      ev_q = QW'($urandom_range(3));
      tick();
      cmp("rnd valid", 32'(o_valid), 32'(now_c < end_c));
      cmp("rnd rank", 32'(o_rank), 32'(m_rank));
      cmp("rnd rem", 32'(o_rem), 32'(m_rem()));
      cmp("rnd cnt", 32'(o_cnt), 32'(m_cnt));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
